// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: widths,
// the bubble instruction word, fetch FSM state encodings and PC helpers.
package if_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    // sll $0,$0,0 -- the canonical MIPS no-op used for bubbles and flushes.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // S_REQ : a fetch is (or is about to be) outstanding on imem.
    // S_HOLD: a fetched word is parked in the skid buffer while decode stalls.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Sequential PC; wraps modulo 2^32 naturally.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold, or flush to a bubble.
// Registered outputs feed decode directly.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_ir,
    input  logic [PC_W-1:0]    i_npc,
    output logic [INSTR_W-1:0] o_ir,
    output logic [PC_W-1:0]    o_npc,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_npc;
    logic               r_valid;

    // Flush beats load; with neither asserted the register holds (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with <= so every register samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_ir    <= BUBBLE_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // npc is left alone: a bubble carries no meaningful next-PC.
            r_ir    <= BUBBLE_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_ir    <= i_ir;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end
    end

    assign o_ir    = r_ir;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch handshake with
// instruction memory, and drives the IF/ID register into decode. Handles
// decode stalls (one-entry skid buffer) and MEM-stage branch redirects.
module if_stage
    import if_stage_pkg::INSTR_W, if_stage_pkg::PC_W, if_stage_pkg::state_t,
           if_stage_pkg::S_REQ, if_stage_pkg::S_HOLD,
           if_stage_pkg::pc_next, if_stage_pkg::word_align;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_in,
    input  logic               pcsrc_in,
    input  logic [PC_W-1:0]    branch_target_in,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IR_out,
    output logic [PC_W-1:0]    npc_out,
    output logic               valid_out
);

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_req;
    logic               r_drop;     // next ack belongs to a fetch killed by a redirect
    logic [INSTR_W-1:0] r_buf_ir;
    logic [PC_W-1:0]    r_buf_npc;

    logic               w_ack;
    logic [PC_W-1:0]    w_pc_plus4;
    logic               w_ifid_load;
    logic               w_ifid_flush;
    logic [INSTR_W-1:0] w_ifid_ir;
    logic [PC_W-1:0]    w_ifid_npc;

    // An ack only counts against a live request; stray acks are ignored.
    assign w_ack      = imem_ack & r_req;
    assign w_pc_plus4 = pc_next(r_pc);

    assign imem_req  = r_req;
    assign imem_addr = r_pc;

    // PC, request and skid-buffer control; redirect outranks stall and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid buffer is a pair of plain registers, so it is
            // reset with the control state; whether it is occupied is carried
            // by r_state alone, never by its contents.
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_drop    <= 1'b0;
            r_buf_ir  <= NOP_INSTR;
            r_buf_npc <= '0;
        end else if (pcsrc_in) begin
            r_pc      <= word_align(branch_target_in);
            r_state   <= S_REQ;
            r_req     <= 1'b1;
            // A fetch still in flight will return stale data; an ack landing
            // this very cycle is discarded here and retires the drop.
            r_drop    <= r_req & ~imem_ack;
            r_buf_ir  <= NOP_INSTR;
            r_buf_npc <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    r_req <= 1'b1;
                    if (w_ack) begin
                        if (r_drop) begin
                            r_drop <= 1'b0;
                        end else if (stall_in) begin
                            r_buf_ir  <= imem_rdata;
                            r_buf_npc <= w_pc_plus4;
                            r_req     <= 1'b0;
                            r_state   <= S_HOLD;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_in) begin
                        r_pc    <= w_pc_plus4;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // IF/ID steering: flush on redirect, drain the buffer, take fresh data,
    // or insert a bubble when decode is ready but nothing usable arrived.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves a
        // signal unassigned and infers a latch.
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_ir    = imem_rdata;
        w_ifid_npc   = w_pc_plus4;
        if (pcsrc_in) begin
            w_ifid_flush = 1'b1;
        end else if (r_state == S_HOLD) begin
            if (!stall_in) begin
                w_ifid_load = 1'b1;
                w_ifid_ir   = r_buf_ir;
                w_ifid_npc  = r_buf_npc;
            end
        end else if (!stall_in) begin
            if (w_ack && !r_drop) begin
                w_ifid_load = 1'b1;
            end else begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_ir    (w_ifid_ir),
        .i_npc   (w_ifid_npc),
        .o_ir    (IR_out),
        .o_npc   (npc_out),
        .o_valid (valid_out)
    );

endmodule
